clk_period_meter: RTL and testbench

//  Downstream monitor for the clock divider output. Synchronises the divided clock (clkin) into the clk

---
 rtl/clk_period_meter.sv | 97 +++++++++
 tb/tb_clk_period_meter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: synchronises clkin, ticks on its rising edges, measures the period and flags mismatch/stall
//   clk, reset            system clock, synchronous active-high reset
//   enable                1 = measure, 0 = idle (no ticks, flags cleared)
//   clkin                 divided clock, asynchronous to clk
//   exp_period            expected period in clk cycles, sampled on tick cycles
//   tick                  one-cycle pulse per synchronised clkin rising edge
//   period, period_valid  last complete edge-to-edge measurement
//   mismatch, timeout     period != exp_period; no edge for TIMEOUT cycles
module clk_period_meter #(
  parameter int CNT_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clkin,
  input  logic [CNT_W-1:0] exp_period,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             mismatch,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, STALL} state_t;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic s, prev;
  logic [CNT_W-1:0] cnt, cnt_nx, period_nx;
  logic valid_nx, mismatch_nx, timeout_nx;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
      mismatch <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clkin};
      prev <= s;
      tick <= s & ~prev & enable;
      state <= state_nx;
      cnt <= cnt_nx;
      period <= period_nx;
      period_valid <= valid_nx;
      mismatch <= mismatch_nx;
      timeout <= timeout_nx;
    end
  // The FSM reacts to the registered tick, so a tick cycle is the cycle tick is high.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    period_nx = period;
    valid_nx = period_valid;
    mismatch_nx = mismatch;
    timeout_nx = timeout;
    if (!enable || state == IDLE) begin
      state_nx = enable ? ARM : IDLE;
      cnt_nx = '0;
      valid_nx = 1'b0;
      mismatch_nx = 1'b0;
      timeout_nx = 1'b0;
    end else
      case (state)
        ARM: begin
          state_nx = tick ? MEASURE : ARM;
          cnt_nx = tick ? ONE : cnt;
        end
        MEASURE:
          if (tick) begin
            period_nx = cnt;
            valid_nx = 1'b1;
            mismatch_nx = cnt != exp_period;
            cnt_nx = ONE;
          end else if (cnt == TO) begin
            state_nx = STALL;
            timeout_nx = 1'b1;
          end else
            cnt_nx = cnt + ONE;
        STALL:
          // The interval that ends here started before the stall, so period is left alone.
          if (tick) begin
            state_nx = MEASURE;
            timeout_nx = 1'b0;
            cnt_nx = ONE;
          end
        default: state_nx = IDLE;
      endcase
  end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized scoreboard bench for clk_period_meter
module tb_clk_period_meter;
  localparam int TO = 20;
  typedef struct {int t; int period; int valid; int mm;} rec_t;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, clkin = 1'b0;
  logic [7:0] exp_period = 8'd0;
  logic tick, period_valid, mismatch, timeout;
  logic [7:0] period;
  int ec = 0, total = 0, passed = 0;
  rec_t tq[$];
  int toq[$];
  rec_t cur;
  bit pend = 1'b0, to_d = 1'b0, measuring = 1'b0;
  int m_period = 0, m_valid = 0, m_mm = 0, last_t = 0;
  clk_period_meter #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clkin(clkin), .exp_period(exp_period),
    .tick(tick), .period(period), .period_valid(period_valid), .mismatch(mismatch), .timeout(timeout)
  );
  always #10 clk = ~clk;
  always @(posedge clk) ec++;
  function automatic void chk(string n, int a, int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", n, ec, a, e);
  endfunction
  always @(negedge clk) begin
    if (pend) begin
      chk("period", int'(period), cur.period);
      chk("period_valid", int'(period_valid), cur.valid);
      chk("mismatch", int'(mismatch), cur.mm);
      chk("timeout_after_tick", int'(timeout), 0);
      pend = 1'b0;
    end
    if (tick) begin
      if (tq.size() == 0) chk("unexpected_tick", ec, -1);
      else begin
        cur = tq.pop_front();
        chk("tick_time", ec, cur.t);
        pend = 1'b1;
      end
    end
    if (timeout && !to_d) begin
      if (toq.size() == 0) chk("unexpected_timeout", ec, -1);
      else chk("timeout_time", ec, toq.pop_front());
    end
    to_d = timeout;
  end
  // Rise at a negedge: first sampled at the next edge, tick visible three edges on.
  task automatic pulse(int g, int h, int e, bit last, bit stall);
    int t, gap, hh;
    @(negedge clk);
    t = ec + 3;
    gap = t - last_t;
    if (e < 0) e = ($urandom_range(0, 1) == 1) ? gap : int'($urandom_range(2, 30));
    exp_period = 8'(e);
    if (!measuring) measuring = 1'b1;
    else if (gap <= TO) begin
      m_period = gap;
      m_valid = 1;
      m_mm = int'(gap != e);
    end
    tq.push_back('{t, m_period, m_valid, m_mm});
    if (last ? stall : (g > TO)) toq.push_back(t + TO + 1);
    last_t = t;
    clkin = 1'b1;
    hh = last ? 2 : (h > 0 ? h : int'($urandom_range(2, g - 2)));
    repeat (hh) @(negedge clk);
    clkin = 1'b0;
    repeat (last ? (stall ? TO + 6 : 3) : g - hh - 1) @(negedge clk);
  endtask
  task automatic run(int n, bit stall);
    for (int i = 0; i < n; i++)
      pulse(($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 26)) : int'($urandom_range(4, 12)),
            0, -1, i == n - 1, stall);
  endtask
  task automatic check_zero(string n);
    chk({n, "_tick"}, int'(tick), 0);
    chk({n, "_period"}, int'(period), 0);
    chk({n, "_valid"}, int'(period_valid), 0);
    chk({n, "_mismatch"}, int'(mismatch), 0);
    chk({n, "_timeout"}, int'(timeout), 0);
  endtask
  initial begin
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clkin = ~clkin;
      check_zero("reset");
    end
    clkin = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) pulse(8, 4, 8, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) pulse(8, 4, 6, 1'b0, 1'b0);
    pulse(8, 4, 8, 1'b0, 1'b0);
    pulse(30, 4, 8, 1'b0, 1'b0);
    pulse(8, 4, 8, 1'b0, 1'b0);
    pulse(20, 4, 8, 1'b0, 1'b0);
    pulse(9, 4, 20, 1'b0, 1'b0);
    run(12, 1'b1);
    run(4, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_valid", int'(period_valid), 0);
    chk("disable_mismatch", int'(mismatch), 0);
    measuring = 1'b0;
    m_valid = 0;
    m_mm = 0;
    repeat (3) @(negedge clk);
    clkin = 1'b1;
    repeat (6) @(negedge clk);
    chk("disabled_no_tick", int'(tick), 0);
    clkin = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    run(6, 1'b1);
    run(4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    measuring = 1'b0;
    m_period = 0;
    m_valid = 0;
    m_mm = 0;
    run(8, 1'b1);
    repeat (4) @(negedge clk);
    chk("ticks_outstanding", tq.size(), 0);
    chk("timeouts_outstanding", toq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
